// File: rtl/cam_link_pkg.sv
// Shared CameraLink base-configuration constants: control bit positions,
// per-port bit maps and the transmit FSM state encoding.
package cam_link_pkg;

  localparam int CAM_W = 28;
  localparam int PIX_W = 24;

  localparam logic [4:0] LVAL_BIT  = 5'd24;
  localparam logic [4:0] FVAL_BIT  = 5'd25;
  localparam logic [4:0] DVAL_BIT  = 5'd26;
  localparam logic [4:0] SPARE_BIT = 5'd23;

  // Element [i] is the CameraLink bit carrying port bit i.
  typedef logic [7:0][4:0] port_map_t;

  localparam port_map_t PORT_A_MAP = {5'd5,  5'd27, 5'd6,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0};
  localparam port_map_t PORT_B_MAP = {5'd11, 5'd10, 5'd14, 5'd13, 5'd12, 5'd9,  5'd8,  5'd7};
  localparam port_map_t PORT_C_MAP = {5'd17, 5'd16, 5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd15};

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_FV_LEAD,
    ST_LINE_WAIT,
    ST_ACTIVE,
    ST_HBLANK,
    ST_FV_TRAIL,
    ST_VBLANK
  } state_t;

endpackage

// File: rtl/axis_cam_out_if.sv
// AXI4-Stream video pixel bus (24-bit RBG, tuser = start of frame, tlast = end of line).
interface axis_cam_out_if;
  import cam_link_pkg::*;

  logic [PIX_W-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic             tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/cam_data_packer.sv
// Combinational packer: 24-bit RBG pixel plus LVAL/FVAL/DVAL into the
// 28-bit CameraLink base word. Exact inverse of the receive-side parser.
module cam_data_packer
  import cam_link_pkg::*;
(
  input  logic [PIX_W-1:0] pixel,
  input  logic             lval,
  input  logic             fval,
  input  logic             dval,
  output wire  [CAM_W-1:0] cam_word
);

  for (genvar i = 0; i < 8; i++) begin : g_port_bits
    assign cam_word[PORT_A_MAP[i]] = pixel[8+i];
    assign cam_word[PORT_B_MAP[i]] = pixel[i];
    assign cam_word[PORT_C_MAP[i]] = pixel[16+i];
  end

  assign cam_word[LVAL_BIT]  = lval;
  assign cam_word[FVAL_BIT]  = fval;
  assign cam_word[DVAL_BIT]  = dval;
  assign cam_word[SPARE_BIT] = 1'b0;

endmodule

// File: rtl/axis_cam_out.sv
// AXI4-Stream video to CameraLink base transmit word with generated
// FVAL/LVAL/DVAL timing, programmable blanking and frame re-alignment.
module axis_cam_out
  import cam_link_pkg::*;
#(
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int FV_SETUP = 4,
  parameter int FV_HOLD  = 4,
  parameter int V_BLANK  = 64
) (
  input  logic             aclk,
  input  logic             aresetn,
  axis_cam_out_if.slave    s_axis,
  output logic [CAM_W-1:0] cam_data_out,
  output logic             underflow,
  output logic             sync_err
);

  localparam logic [15:0] V_ACTIVE_C  = 16'(V_ACTIVE);
  localparam logic [15:0] LD_H_BLANK  = 16'(H_BLANK - 1);
  localparam logic [15:0] LD_FV_SETUP = 16'(FV_SETUP - 1);
  localparam logic [15:0] LD_FV_HOLD  = 16'(FV_HOLD - 1);
  localparam logic [15:0] LD_V_BLANK  = 16'(V_BLANK - 1);

  state_t           state, state_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic [15:0]      line_cnt, line_cnt_nxt;
  logic             hold_vld, hold_vld_nxt;
  logic [PIX_W-1:0] hold_data, hold_data_nxt;
  logic             hold_last, hold_last_nxt;
  logic             run;
  logic             tready;
  logic             accept;
  logic             line_end;

  logic             fval_p0, lval_p0, dval_p0;
  logic             underflow_p0, sync_err_p0;
  logic [PIX_W-1:0] pix_p0;
  logic [CAM_W-1:0] cam_word_p0;

  // Ready depends only on registered state and holding-register occupancy.
  always_comb begin
    tready = 1'b0;
    if (run) begin
      case (state)
        ST_SYNC, ST_ACTIVE: tready = !hold_vld;
        ST_LINE_WAIT:       tready = 1'b1;
        default:            tready = 1'b0;
      endcase
    end
  end

  assign s_axis.tready = tready;
  assign accept        = tready & s_axis.tvalid;

  // Next-state, counters, holding register and the word for this cycle.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    line_cnt_nxt  = line_cnt;
    hold_vld_nxt  = hold_vld;
    hold_data_nxt = hold_data;
    hold_last_nxt = hold_last;
    fval_p0       = 1'b0;
    lval_p0       = 1'b0;
    dval_p0       = 1'b0;
    pix_p0        = '0;
    underflow_p0  = 1'b0;
    sync_err_p0   = 1'b0;
    line_end      = 1'b0;

    case (state)
      ST_SYNC: begin
        if (hold_vld) begin
          state_nxt    = ST_FV_LEAD;
          cnt_nxt      = LD_FV_SETUP;
          line_cnt_nxt = '0;
        end else if (accept && s_axis.tuser) begin
          hold_vld_nxt  = 1'b1;
          hold_data_nxt = s_axis.tdata;
          hold_last_nxt = s_axis.tlast;
          state_nxt     = ST_FV_LEAD;
          cnt_nxt       = LD_FV_SETUP;
          line_cnt_nxt  = '0;
        end
      end
      ST_FV_LEAD: begin
        fval_p0 = 1'b1;
        if (cnt == 16'd0) state_nxt = ST_ACTIVE;
        else              cnt_nxt   = cnt - 16'd1;
      end
      ST_LINE_WAIT: begin
        fval_p0 = 1'b1;
        if (accept) begin
          if (s_axis.tuser) begin
            // Early start of frame: close this frame and keep the beat for the next.
            sync_err_p0   = 1'b1;
            hold_vld_nxt  = 1'b1;
            hold_data_nxt = s_axis.tdata;
            hold_last_nxt = s_axis.tlast;
            state_nxt     = ST_FV_TRAIL;
            cnt_nxt       = LD_FV_HOLD;
          end else begin
            lval_p0   = 1'b1;
            dval_p0   = 1'b1;
            pix_p0    = s_axis.tdata;
            line_end  = s_axis.tlast;
            state_nxt = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        fval_p0 = 1'b1;
        lval_p0 = 1'b1;
        if (hold_vld) begin
          dval_p0      = 1'b1;
          pix_p0       = hold_data;
          hold_vld_nxt = 1'b0;
          line_end     = hold_last;
        end else if (accept) begin
          dval_p0     = 1'b1;
          pix_p0      = s_axis.tdata;
          sync_err_p0 = s_axis.tuser;
          line_end    = s_axis.tlast;
        end else begin
          underflow_p0 = 1'b1;
        end
      end
      ST_HBLANK: begin
        fval_p0 = 1'b1;
        if (cnt == 16'd0) state_nxt = ST_LINE_WAIT;
        else              cnt_nxt   = cnt - 16'd1;
      end
      ST_FV_TRAIL: begin
        fval_p0 = 1'b1;
        if (cnt == 16'd0) begin
          state_nxt = ST_VBLANK;
          cnt_nxt   = LD_V_BLANK;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      ST_VBLANK: begin
        if (cnt == 16'd0) state_nxt = ST_SYNC;
        else              cnt_nxt   = cnt - 16'd1;
      end
      default: state_nxt = ST_SYNC;
    endcase

    if (line_end) begin
      line_cnt_nxt = line_cnt + 16'd1;
      if (line_cnt + 16'd1 == V_ACTIVE_C) begin
        state_nxt = ST_FV_TRAIL;
        cnt_nxt   = LD_FV_HOLD;
      end else begin
        state_nxt = ST_HBLANK;
        cnt_nxt   = LD_H_BLANK;
      end
    end
  end

  cam_data_packer u_packer (
    .pixel    (pix_p0),
    .lval     (lval_p0),
    .fval     (fval_p0),
    .dval     (dval_p0),
    .cam_word (cam_word_p0)
  );

  // p0 -> output register: control state and the registered CameraLink word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_SYNC;
      cnt          <= '0;
      line_cnt     <= '0;
      hold_vld     <= 1'b0;
      hold_data    <= '0;
      hold_last    <= 1'b0;
      run          <= 1'b0;
      cam_data_out <= '0;
      underflow    <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      line_cnt     <= line_cnt_nxt;
      hold_vld     <= hold_vld_nxt;
      hold_data    <= hold_data_nxt;
      hold_last    <= hold_last_nxt;
      run          <= 1'b1;
      cam_data_out <= cam_word_p0;
      underflow    <= underflow_p0;
      sync_err     <= sync_err_p0;
    end
  end

endmodule

// File: tb/tb_axis_cam_out.sv
// Directed bench for axis_cam_out with a small blanking configuration.
module tb_axis_cam_out;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [27:0] cam_data_out;
  logic        underflow;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  logic [27:0] w;
  logic        uf, se, acc;

  localparam logic [27:0] PIX_MASK = 28'h87FFFFF;

  axis_cam_out_if axis ();

  axis_cam_out #(
    .V_ACTIVE (2),
    .H_BLANK  (3),
    .FV_SETUP (2),
    .FV_HOLD  (2),
    .V_BLANK  (4)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis       (axis),
    .cam_data_out (cam_data_out),
    .underflow    (underflow),
    .sync_err     (sync_err)
  );

  always #5 aclk = ~aclk;

  // Receive-side decode of the CameraLink ports.
  function automatic logic [7:0] dec_a(input logic [27:0] v);
    return {v[5], v[27], v[6], v[4], v[3], v[2], v[1], v[0]};
  endfunction
  function automatic logic [7:0] dec_b(input logic [27:0] v);
    return {v[11], v[10], v[14], v[13], v[12], v[9], v[8], v[7]};
  endfunction
  function automatic logic [7:0] dec_c(input logic [27:0] v);
    return {v[17], v[16], v[22], v[21], v[20], v[19], v[18], v[15]};
  endfunction
  function automatic logic [23:0] dec_pix(input logic [27:0] v);
    return {dec_c(v), dec_a(v), dec_b(v)};
  endfunction

  // One clock: drive a beat, note whether it was accepted, capture the word it produced.
  task automatic cyc(input logic v, input logic [23:0] d, input logic l, input logic u);
    axis.tvalid = v;
    axis.tdata  = d;
    axis.tlast  = l;
    axis.tuser  = u;
    @(negedge aclk);
    acc = axis.tready & v;
    @(posedge aclk);
    #1;
    w  = cam_data_out;
    uf = underflow;
    se = sync_err;
  endtask

  task automatic do_reset();
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (cam_data_out !== 28'h0) begin errors++; $display("FAIL reset_cam got %h want %h", cam_data_out, 28'h0); end
    checks++;
    if (axis.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", axis.tready); end
    checks++;
    if ({underflow, sync_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {underflow, sync_err}); end
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if (axis.tready !== 1'b1) begin errors++; $display("FAIL reset_tready_rise got %b want 1", axis.tready); end
    checks++;
    if (cam_data_out !== 28'h0) begin errors++; $display("FAIL reset_idle_cam got %h want 0", cam_data_out); end
  endtask

  task automatic test_frame();
    logic [23:0] pix [8];
    logic [0:20] e_fv, e_lv;
    int k, j;
    pix  = '{24'hA5C33C, 24'h010203, 24'h102030, 24'hFFFFFF,
             24'h800001, 24'h7E7E7E, 24'h00FF00, 24'h123456};
    e_fv = 21'b011111111111111100000;
    e_lv = 21'b000111100011110000000;
    do_reset();
    k = 0;
    j = 0;
    for (int c = 0; c < 21; c++) begin
      if (k < 8) cyc(1'b1, pix[k], (k == 3) || (k == 7), k == 0);
      else       cyc(1'b0, 24'h0, 1'b0, 1'b0);
      if (acc) k++;
      checks++;
      if (w[25] !== e_fv[c]) begin errors++; $display("FAIL frame_fval c=%0d got %b want %b", c, w[25], e_fv[c]); end
      checks++;
      if (w[24] !== e_lv[c]) begin errors++; $display("FAIL frame_lval c=%0d got %b want %b", c, w[24], e_lv[c]); end
      checks++;
      if (w[26] !== e_lv[c]) begin errors++; $display("FAIL frame_dval c=%0d got %b want %b", c, w[26], e_lv[c]); end
      checks++;
      if (w[23] !== 1'b0) begin errors++; $display("FAIL frame_spare c=%0d got %b want 0", c, w[23]); end
      if (w[26] === 1'b1 && j < 8) begin
        checks++;
        if (dec_pix(w) !== pix[j]) begin errors++; $display("FAIL frame_pixel c=%0d got %h want %h", c, dec_pix(w), pix[j]); end
        j++;
      end else begin
        checks++;
        if ((w & PIX_MASK) !== 28'h0) begin errors++; $display("FAIL frame_blank_pixel c=%0d got %h want 0", c, w & PIX_MASK); end
      end
      if (c == 3) begin
        checks++;
        if (w !== 28'hF4AF223) begin errors++; $display("FAIL packing_word got %h want %h", w, 28'hF4AF223); end
        checks++;
        if ({dec_c(w), dec_a(w), dec_b(w)} !== {8'hA5, 8'hC3, 8'h3C})
          begin errors++; $display("FAIL packing_ports got %h want a5c33c", {dec_c(w), dec_a(w), dec_b(w)}); end
      end
    end
    checks++;
    if (j !== 8) begin errors++; $display("FAIL frame_pixel_count got %0d want 8", j); end
  endtask

  task automatic test_drop();
    logic [23:0] pix [6];
    int k;
    pix = '{24'h111111, 24'h222222, 24'h333333, 24'hABCDEF, 24'h445566, 24'h778899};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, pix[c], 1'b0, 1'b0);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL drop_accept c=%0d got %b want 1", c, acc); end
      checks++;
      if (w !== 28'h0) begin errors++; $display("FAIL drop_word c=%0d got %h want 0", c, w); end
    end
    k = 3;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, pix[k], 1'b0, k == 3);
      if (acc) k++;
      if (c == 0) begin
        checks++;
        if (w !== 28'h0) begin errors++; $display("FAIL drop_sof_word got %h want 0", w); end
      end else if (c < 3) begin
        checks++;
        if (w[26:24] !== 3'b010) begin errors++; $display("FAIL drop_lead c=%0d got %b want 010", c, w[26:24]); end
      end else begin
        checks++;
        if (w[26:24] !== 3'b111) begin errors++; $display("FAIL drop_first_ctrl got %b want 111", w[26:24]); end
        checks++;
        if (dec_pix(w) !== 24'hABCDEF) begin errors++; $display("FAIL drop_first_pixel got %h want abcdef", dec_pix(w)); end
      end
    end
  endtask

  task automatic test_underflow();
    logic [23:0] pix [4];
    logic [0:9] e_lv, e_dv, e_uf;
    int k, j, ndv;
    pix  = '{24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C, 24'h3A3B3C};
    e_lv = 10'b0001111110;
    e_dv = 10'b0001100110;
    e_uf = 10'b0000011000;
    do_reset();
    k = 0;
    j = 0;
    ndv = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5 || c == 6 || k >= 4) cyc(1'b0, 24'h0, 1'b0, 1'b0);
      else                            cyc(1'b1, pix[k], k == 3, k == 0);
      if (acc) k++;
      checks++;
      if (w[24] !== e_lv[c]) begin errors++; $display("FAIL uf_lval c=%0d got %b want %b", c, w[24], e_lv[c]); end
      checks++;
      if (w[26] !== e_dv[c]) begin errors++; $display("FAIL uf_dval c=%0d got %b want %b", c, w[26], e_dv[c]); end
      checks++;
      if (uf !== e_uf[c]) begin errors++; $display("FAIL uf_pulse c=%0d got %b want %b", c, uf, e_uf[c]); end
      if (w[26] === 1'b1 && j < 4) begin
        ndv++;
        checks++;
        if (dec_pix(w) !== pix[j]) begin errors++; $display("FAIL uf_pixel c=%0d got %h want %h", c, dec_pix(w), pix[j]); end
        j++;
      end
      if (e_uf[c]) begin
        checks++;
        if ((w & PIX_MASK) !== 28'h0) begin errors++; $display("FAIL uf_pixel_zero c=%0d got %h want 0", c, w & PIX_MASK); end
      end
    end
    checks++;
    if (ndv !== 4) begin errors++; $display("FAIL uf_line_len got %0d want 4", ndv); end
  endtask

  task automatic test_mid_tuser();
    logic [23:0] pix [4];
    logic [0:5] e_se;
    int k;
    pix  = '{24'h000001, 24'h0000F0, 24'h000F00, 24'h00F000};
    e_se = 6'b000010;
    do_reset();
    k = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, pix[k], k == 3, k <= 1);
      if (acc) k++;
      checks++;
      if (se !== e_se[c]) begin errors++; $display("FAIL mid_sync_err c=%0d got %b want %b", c, se, e_se[c]); end
      if (c == 4) begin
        checks++;
        if (w[26] !== 1'b1 || dec_pix(w) !== 24'h0000F0)
          begin errors++; $display("FAIL mid_pixel got dval=%b pix=%h want dval=1 pix=0000f0", w[26], dec_pix(w)); end
      end
    end
  endtask

  task automatic test_linewait_tuser();
    logic [23:0] pix [8];
    logic [0:21] e_fv, e_dv, e_se;
    int k, j;
    pix  = '{24'hC0FFEE, 24'h000011, 24'h000022, 24'h000033,
             24'h5A5A5A, 24'h000055, 24'h000066, 24'h000077};
    e_fv = 22'b0111111111111000001111;
    e_dv = 22'b0001111000000000000011;
    e_se = 22'b0000000000100000000000;
    do_reset();
    k = 0;
    j = 0;
    for (int c = 0; c < 22; c++) begin
      cyc(1'b1, pix[k], (k == 3) || (k == 7), (k == 0) || (k == 4));
      if (acc) k++;
      checks++;
      if (w[25] !== e_fv[c]) begin errors++; $display("FAIL lw_fval c=%0d got %b want %b", c, w[25], e_fv[c]); end
      checks++;
      if (w[26] !== e_dv[c] || w[24] !== e_dv[c])
        begin errors++; $display("FAIL lw_lval_dval c=%0d got %b%b want %b%b", c, w[24], w[26], e_dv[c], e_dv[c]); end
      checks++;
      if (se !== e_se[c]) begin errors++; $display("FAIL lw_sync_err c=%0d got %b want %b", c, se, e_se[c]); end
      if (w[26] === 1'b1 && j < 8) begin
        checks++;
        if (dec_pix(w) !== pix[j]) begin errors++; $display("FAIL lw_pixel c=%0d got %h want %h", c, dec_pix(w), pix[j]); end
        j++;
      end
    end
    checks++;
    if (j !== 6) begin errors++; $display("FAIL lw_pixel_count got %0d want 6", j); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] pix [4];
    int k;
    pix = '{24'h123123, 24'h456456, 24'h789789, 24'hABCABC};
    do_reset();
    k = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, pix[k], k == 3, k == 0);
      if (acc) k++;
    end
    checks++;
    if (w[26:24] !== 3'b111) begin errors++; $display("FAIL rstmid_in_line got %b want 111", w[26:24]); end
    aresetn = 1'b0;
    #1;
    checks++;
    if (cam_data_out !== 28'h0) begin errors++; $display("FAIL rstmid_async_cam got %h want 0", cam_data_out); end
    checks++;
    if (axis.tready !== 1'b0) begin errors++; $display("FAIL rstmid_tready got %b want 0", axis.tready); end
    axis.tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, pix[c % 4], 1'b0, 1'b0);
      checks++;
      if (w !== 28'h0) begin errors++; $display("FAIL rstmid_no_tuser c=%0d got %h want 0", c, w); end
    end
    cyc(1'b1, 24'h999999, 1'b0, 1'b1);
    cyc(1'b1, 24'h888888, 1'b0, 1'b0);
    checks++;
    if (w[25] !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_sof got %b want 1", w[25]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    test_drop();
    test_underflow();
    test_mid_tuser();
    test_linewait_tuser();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
